// File: rtl/mac_pkg.sv
// Shared definitions for the MAC lane, its job sequencer and the tile scheduler.
package mac_pkg;

  localparam int MAC_OP_W  = 8;
  localparam int MAC_ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } mac_state_e;

  // Operands reach the lane only when enabled; otherwise the lane sees zero and holds.
  function automatic logic [MAC_OP_W-1:0] gate_op(input logic en, input logic [MAC_OP_W-1:0] v);
    return en ? v : {MAC_OP_W{1'b0}};
  endfunction

endpackage

// File: rtl/mac_len_cnt.sv
// Loadable down-counter tracking the operand pairs still owed to the current job.
module mac_len_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [LEN_W-1:0] load_val,
  output logic             last,
  output logic             zero
);

  logic [LEN_W-1:0] rem;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= {LEN_W{1'b0}};
    end else if (load) begin
      rem <= load_val;
    end else if (dec && (rem != {LEN_W{1'b0}})) begin
      rem <= rem - LEN_W'(1);
    end else begin
      rem <= rem;
    end
  end

  always_comb begin
    last = (rem == LEN_W'(1));
    zero = (rem == {LEN_W{1'b0}});
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: clears the MAC lane, streams K operand pairs into it
// and returns the final accumulator on a result handshake.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [MAC_OP_W-1:0] op_a,
  input  logic [MAC_OP_W-1:0] op_b,
  output logic                mac_clr,
  output logic [MAC_OP_W-1:0] mac_a,
  output logic [MAC_OP_W-1:0] mac_b,
  input  logic [ACC_W-1:0]    mac_acc,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_W-1:0]    res_data,
  output logic [LEN_W-1:0]    res_len,
  output logic                busy
);

  mac_state_e state;
  logic       cmd_hs;
  logic       op_hs;
  logic       cnt_last;
  logic       cnt_zero;

  mac_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_hs),
    .dec      (op_hs),
    .load_val (cmd_len),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // Handshake outputs decode the state; all are forced inactive while rst is high,
  // and the lane is held cleared during reset so a killed job leaves no residue.
  always_comb begin
    cmd_ready = (!rst) && (state == IDLE);
    op_ready  = (!rst) && (state == STREAM);
    res_valid = (!rst) && (state == DONE);
    busy      = (!rst) && (state != IDLE);
    mac_clr   = rst || (state == CLEAR);
    cmd_hs    = cmd_valid && cmd_ready;
    op_hs     = op_valid && op_ready;
    mac_a     = gate_op(op_hs, op_a);
    mac_b     = gate_op(op_hs, op_b);
  end

  // Job FSM plus result register; res_data moves only on the DRAIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      res_data <= {ACC_W{1'b0}};
      res_len  <= {LEN_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            res_len <= cmd_len;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          state <= cnt_zero ? DRAIN : STREAM;
        end
        STREAM: begin
          if (op_hs && cnt_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          res_data <= mac_acc;
          state    <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl driving a behavioural MAC lane model.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int LEN_W = 8;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             mac_clr;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [ACC_W-1:0] mac_acc;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [LEN_W-1:0] res_len;
  logic             busy;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mac_clr   (mac_clr),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_len   (res_len),
    .busy      (busy)
  );

  // Lane model: unsigned a times signed b, sign-extended into the accumulator.
  logic [ACC_W-1:0]   acc;
  logic signed [16:0] prod;
  always_comb prod = $signed({1'b0, mac_a}) * $signed(mac_b);
  always_ff @(posedge clk) begin
    if (mac_clr) acc <= 32'd0;
    else         acc <= acc + {{15{prod[16]}}, prod};
  end
  assign mac_acc = acc;

  int tests = 0;
  int fails = 0;
  logic [7:0] va [256];
  logic [7:0] vb [256];
  int rv, opr, clr, hs, pt_bad, nz_bad;
  logic cmd_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 256; i++) begin
      va[i] = 8'hAA;
      vb[i] = 8'h55;
    end
  endtask

  // Command in cycle 0, then stream pairs (optional bubble run after pair gap_after);
  // returns at the negedge of the first cycle with res_valid, or after budget cycles.
  task automatic do_job(input int k, input int gap_after, input int gap_len, input int budget);
    int   idx;
    int   gap;
    logic bub;
    idx = 0; gap = 0;
    rv = -1; opr = 0; clr = 0; hs = 0; pt_bad = 0; nz_bad = 0;
    cmd_valid = 1'b1;
    cmd_len   = 8'(k);
    @(negedge clk);
    cmd_seen = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      bub      = (idx == gap_after) && (gap < gap_len);
      op_valid = !bub;
      op_a     = va[idx];
      op_b     = vb[idx];
      @(negedge clk);
      if (mac_clr) clr++;
      if (op_ready) opr++;
      if (op_valid && op_ready) begin
        hs++;
        if ((mac_a !== op_a) || (mac_b !== op_b)) pt_bad++;
      end else if ((mac_a !== 8'd0) || (mac_b !== 8'd0)) begin
        nz_bad++;
      end
      if (res_valid) begin
        rv = c;
        break;
      end
      if (bub) gap++;
      if (op_valid && op_ready && (idx < 255)) idx++;
      tick();
    end
  endtask

  // Consume the result from a DONE negedge and confirm the return to IDLE.
  task automatic finish_result(input string tag);
    res_ready = 1'b1;
    op_valid  = 1'b0;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_cmd_ready"}, 64'(cmd_ready), 64'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0; op_valid = 1'b0;
    op_a = 8'd0; op_b = 8'd0; res_ready = 1'b0;
    fill_default();

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_mac_clr", 64'(mac_clr), 64'd1);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_len", 64'(res_len), 64'd0);
    chk("rst_mac_ab", 64'({mac_a, mac_b}), 64'd0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_mac_clr", 64'(mac_clr), 64'd0);
    tick();

    // Test 1: K=3, no bubbles
    va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3;
    vb[0] = 8'd4; vb[1] = 8'd5; vb[2] = 8'd6;
    do_job(3, 0, 0, 50);
    chk("t1_cmd_ready", 64'(cmd_seen), 64'd1);
    chk("t1_res_cycle", 64'(rv), 64'd6);
    chk("t1_op_ready_cycles", 64'(opr), 64'd3);
    chk("t1_handshakes", 64'(hs), 64'd3);
    chk("t1_clr_pulses", 64'(clr), 64'd1);
    chk("t1_passthru", 64'(pt_bad), 64'd0);
    chk("t1_zero_ops", 64'(nz_bad), 64'd0);
    chk("t1_res_data", 64'(res_data), 64'd32);
    chk("t1_res_len", 64'(res_len), 64'd3);
    chk("t1_busy", 64'(busy), 64'd1);

    // Test 4: result held 5 cycles with a K=0 command pending
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    op_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t4_hold_res_valid", 64'(res_valid), 64'd1);
      chk("t4_hold_res_data", 64'(res_data), 64'd32);
      chk("t4_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Test 2: the pending K=0 job, accepted one cycle after the result handshake
    fill_default();
    do_job(0, 0, 0, 50);
    chk("t4_cmd_accept_next", 64'(cmd_seen), 64'd1);
    chk("t2_res_cycle", 64'(rv), 64'd3);
    chk("t2_op_ready_cycles", 64'(opr), 64'd0);
    chk("t2_clr_pulses", 64'(clr), 64'd1);
    chk("t2_zero_ops", 64'(nz_bad), 64'd0);
    chk("t2_res_data", 64'(res_data), 64'd0);
    chk("t2_res_len", 64'(res_len), 64'd0);
    finish_result("t2");

    // Test 3: K=2 with a 3-cycle bubble between pairs
    fill_default();
    va[0] = 8'd10; vb[0] = 8'hFE;
    va[1] = 8'd7;  vb[1] = 8'd3;
    do_job(2, 1, 3, 50);
    chk("t3_res_cycle", 64'(rv), 64'd8);
    chk("t3_handshakes", 64'(hs), 64'd2);
    chk("t3_op_ready_cycles", 64'(opr), 64'd5);
    chk("t3_passthru", 64'(pt_bad), 64'd0);
    chk("t3_bubble_zero", 64'(nz_bad), 64'd0);
    chk("t3_res_data", 64'(res_data), 64'd1);
    chk("t3_res_len", 64'(res_len), 64'd2);
    finish_result("t3");

    // Test 5: reset after 2 of 4 pairs, then K=1 with (255,127)
    cmd_valid = 1'b1;
    cmd_len   = 8'd4;
    tick();
    cmd_valid = 1'b0;
    op_valid  = 1'b1;
    op_a      = 8'd5;
    op_b      = 8'd7;
    tick();
    tick();
    tick();
    op_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("t5_rst_mac_clr", 64'(mac_clr), 64'd1);
    chk("t5_rst_op_ready", 64'(op_ready), 64'd0);
    chk("t5_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_busy", 64'(busy), 64'd0);
    chk("t5_post_op_ready", 64'(op_ready), 64'd0);
    chk("t5_post_res_valid", 64'(res_valid), 64'd0);
    chk("t5_post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t5_post_res_data", 64'(res_data), 64'd0);
    chk("t5_post_lane_acc", 64'(mac_acc), 64'd0);
    tick();
    fill_default();
    va[0] = 8'd255; vb[0] = 8'd127;
    do_job(1, 0, 0, 50);
    chk("t5_res_cycle", 64'(rv), 64'd4);
    chk("t5_res_data", 64'(res_data), 64'd32385);
    chk("t5_res_len", 64'(res_len), 64'd1);
    finish_result("t5");

    // Test 6: maximum length K=255, every pair (255,-128)
    for (int i = 0; i < 256; i++) begin
      va[i] = 8'd255;
      vb[i] = 8'h80;
    end
    do_job(255, 0, 0, 400);
    chk("t6_res_cycle", 64'(rv), 64'd258);
    chk("t6_op_ready_cycles", 64'(opr), 64'd255);
    chk("t6_handshakes", 64'(hs), 64'd255);
    chk("t6_passthru", 64'(pt_bad), 64'd0);
    chk("t6_zero_ops", 64'(nz_bad), 64'd0);
    chk("t6_res_data", 64'(res_data), 64'hFF80FF80);
    chk("t6_res_len", 64'(res_len), 64'd255);
    finish_result("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Job sequencer for a single 8x8→32 multiply-accumulate lane. It accepts a dot-product command of length K, clears the lane's accumulator, and streams exactly K operand pairs into it under a valid/ready handshake. During idle and bubble cycles it drives zero operands so the accumulator holds its value. It then captures the final accumulator and presents it on a result handshake. It sits between the matrix tile scheduler (commands and operands) and the MAC lane (datapath).

## Interface
Parameters:
- `LEN_W`, 8, width of the job length; the maximum K is 2^LEN_W−1.
- `ACC_W`, 32, accumulator/result width; must match the MAC lane.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  job accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_len`  in  LEN_W  K, the number of operand pairs.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  operand pair accepted.
- `op_a`  in  8  unsigned operand.
- `op_b`  in  8  signed operand.
- `mac_clr`  out  1  accumulator clear to the lane (the lane's synchronous reset).
- `mac_a`  out  8  operand a to the lane.
- `mac_b`  out  8  operand b to the lane.
- `mac_acc`  in  ACC_W  the lane's registered accumulator.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  ACC_W  captured dot product.
- `res_len`  out  LEN_W  K of the captured job.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
The controller is an FSM with five states: IDLE, CLEAR, STREAM, DRAIN, DONE.

- **IDLE**
  - `cmd_ready`=1; all other handshake outputs are 0.
  - On a command handshake: latch `cmd_len` into the down-counter `rem` and into `res_len`, then go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `mac_clr`=1.
  - Next state: STREAM if `rem`≠0, otherwise DRAIN.
- **STREAM**
  - `op_ready`=1.
  - On an operand handshake: `mac_a`=`op_a`, `mac_b`=`op_b` (combinational pass-through); `rem` decrements.
  - On the handshake where `rem`==1, go to DRAIN.
  - When there is no handshake (bubble), `mac_a`=`mac_b`=0 and `rem` holds.
- **DRAIN** (exactly 1 cycle)
  - `mac_acc` now includes every product.
  - Register `mac_acc` into `res_data`, then go to DONE.
- **DONE**
  - `res_valid`=1.
  - `res_data` and `res_len` are held stable until `res_ready`; then go to IDLE.

Rules that apply in every state:
- `mac_a` and `mac_b` are 0 in every state other than a STREAM handshake cycle. This guarantees no accumulation outside the job.
- `mac_clr` = `rst` OR (state==CLEAR).
- `cmd_ready` is 0 outside IDLE; commands presented while busy wait at the port.
- `op_ready` is 0 outside STREAM; no pair is ever consumed beyond K.
- Arithmetic is owned by the lane. The controller never alters operand bits and applies no saturation; a sum exceeding ACC_W wraps mod 2^ACC_W, which is unreachable for K≤255 with ACC_W=32.

## Timing
- Reset values:
  - state: IDLE
  - `rem`: 0
  - `res_data`: 0
  - `res_len`: 0
  - `res_valid`, `op_ready`, `busy`: 0
  - `cmd_ready`: 0 while `rst` is high
  - `mac_clr`: 1 while `rst` is high
  - `mac_a`, `mac_b`: 0
- Latency, counted with the command handshake in cycle 0 and no bubbles:
  - CLEAR occupies cycle 1.
  - STREAM occupies cycles 2..K+1.
  - DRAIN occupies cycle K+2.
  - `res_valid` rises in cycle K+3.
  - For K=0, `res_valid` rises in cycle 3.
- Each bubble adds exactly one cycle.
- Back-to-back jobs: a DONE→IDLE handshake returns to IDLE in the next cycle, so a new command can be accepted at earliest 1 cycle after the result handshake.
- Reset asserted mid-job (any state): the next state is IDLE, any partial result is discarded, and the lane is cleared via `mac_clr`.
- `res_data` changes only at the DRAIN edge and on reset.

## Structure
- **Shared package `mac_pkg`:**
  - `mac_state_e` (enum of IDLE, CLEAR, STREAM, DRAIN, DONE).
  - The constants `MAC_OP_W`=8 and `MAC_ACC_W`=32, reused by the lane, the controller and the tile scheduler.
- **Sub-module:** one, `mac_len_cnt`. It is a loadable down-counter with `load`, `dec`, a `last` flag (`rem`==1) and a `zero` flag.
- **Top level:** the FSM and the result register.
- **Lane:** instantiated by the parent, not inside this block.

## Test plan
The bench uses a lane model: acc ≤ clr ? 0 : acc + sign-extended (a_unsigned × b_signed).

1. Reset, then K=3 with pairs a={1,2,3}, b={4,5,6} and no bubbles → `res_data`=32, `res_len`=3, `res_valid` in cycle 6, `op_ready` high for exactly 3 cycles.
2. K=0 → `op_ready` never asserted, `mac_clr` pulses once, `res_data`=0, `res_valid` in cycle 3.
3. K=2 with pairs (10,−2) and (7,3), with `op_valid` low for 3 cycles between them → `res_data`=1, `res_valid` in cycle 8, `mac_a`/`mac_b`=0 during the bubbles.
4. `res_ready` held low for 5 cycles with a second command pending → `res_data`/`res_valid` stable, `cmd_ready`=0; the second command is accepted 1 cycle after the result handshake.
5. `rst` asserted after 2 of 4 pairs → next cycle IDLE, `res_valid`=0, `op_ready`=0, `mac_clr`=1 during `rst`. A following job K=1 with (255,127) → `res_data`=32385.
6. K=255 with every pair (255,−128) → `res_data`=0xFF80FF80, `op_ready` deasserted after the 255th handshake.
